// File: rtl/oisc8_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : oisc8_fetch_unit_if
// Purpose  : Bus bundle between the OISC8 fetch unit, its instruction ROM
//            and the shared 8-bit data bus.
//            master : the fetch unit (drives ROM address, bus data, decode)
//            slave  : the surrounding system (ROM data, resolved bus data)
// Revision : 1.0 - initial release
// ============================================================================
interface oisc8_fetch_unit_if #(
  parameter int SAWIDTH = 7,
  parameter int DAWIDTH = 5
) ();

  logic [9:0]         rom_addr;
  logic [26:0]        rom_data;
  logic [7:0]         data_in;
  logic [7:0]         data_out;
  logic               data_oe;
  logic               imm;
  logic [DAWIDTH-1:0] instr_dst;
  logic [SAWIDTH-1:0] instr_src;

  modport master (
    output rom_addr,
    output data_out,
    output data_oe,
    output imm,
    output instr_dst,
    output instr_src,
    input  rom_data,
    input  data_in
  );

  modport slave (
    input  rom_addr,
    input  data_out,
    input  data_oe,
    input  imm,
    input  instr_dst,
    input  instr_src,
    output rom_data,
    output data_in
  );

endinterface

`default_nettype wire

// File: rtl/oisc8_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : oisc8_fetch_unit
// Purpose  : Instruction fetch and branch unit of the OISC8 move machine.
//            Holds the 16-bit PC, fetches two 13-bit instructions per 27-bit
//            ROM word, decodes them, drives immediate / null / readback data
//            onto the shared bus and implements the branch pointer and
//            branch-on-zero destinations.
//            Optional macro PC_DEBUG_EN adds dbg_pc, dbg_instr, dbg_pointer.
// Revision : 1.0 - initial release
// ============================================================================
module oisc8_fetch_unit #(
  parameter int                 SAWIDTH  = 7,
  parameter int                 DAWIDTH  = 5,
  parameter logic [DAWIDTH-1:0] A_BRPT0  = 5'd1,
  parameter logic [DAWIDTH-1:0] A_BRPT1  = 5'd2,
  parameter logic [DAWIDTH-1:0] A_BRZ    = 5'd3,
  parameter logic [SAWIDTH-1:0] A_BRPT0R = 7'd1,
  parameter logic [SAWIDTH-1:0] A_BRPT1R = 7'd2,
  parameter logic [SAWIDTH-1:0] A_PC0    = 7'd3,
  parameter logic [SAWIDTH-1:0] A_PC1    = 7'd4
) (
  input  logic               clk,
  input  logic               rst,
  oisc8_fetch_unit_if.master bus
`ifdef PC_DEBUG_EN
  ,
  output logic [15:0]        dbg_pc,
  output logic [12:0]        dbg_instr,
  output logic [15:0]        dbg_pointer
`endif
);

  // Architectural state
  logic [15:0]        pcr_q, pcr_d;
  logic               pc0_q, pc0_d;
  logic [15:0]        pointer_q, pointer_d;

  // Decode and PC datapath
  logic [12:0]        instr;
  logic               imm;
  logic [DAWIDTH-1:0] dst;
  logic [SAWIDTH-1:0] src;
  logic [7:0]         cmp;
  logic               branch;
  logic [15:0]        pc;
  logic [15:0]        pcn;

  // Bus driver
  logic [7:0]         drv_data;
  logic               drv_oe;

  // The low bit of the ROM word carries no instruction bits.
  logic               unused_rom_lsb;
  assign unused_rom_lsb = bus.rom_data[0];

  // pc0_q remembers which half of the word was addressed when the ROM sampled it.
  assign instr  = pc0_q ? bus.rom_data[26:14] : bus.rom_data[13:1];
  assign imm    = instr[12];
  assign dst    = instr[11:SAWIDTH];
  assign src    = imm ? '0 : instr[SAWIDTH-1:0];

  // Anything not written to BRZ compares as nonzero, so only a BRZ move of
  // 0x00 redirects the fetch.
  assign cmp    = (dst == A_BRZ) ? bus.data_in : 8'hFF;
  assign branch = (cmp == 8'h00);

  // The PC is combinational so a taken branch addresses its target in the
  // same cycle; reset forces fetch from address zero immediately.
  assign pc     = !rst ? 16'h0000 : (branch ? pointer_q : pcr_q);
  assign pcn    = pc + 16'd1;

  // Bus source selection in priority order: immediate, null, pointer, PC+1.
  always_comb begin
    drv_data = 8'h00;
    drv_oe   = 1'b0;
    if (imm) begin
      drv_data = instr[7:0];
      drv_oe   = 1'b1;
    end else if (src == '0) begin
      drv_data = 8'h00;
      drv_oe   = 1'b1;
    end else if (src == A_BRPT0R) begin
      drv_data = pointer_q[7:0];
      drv_oe   = 1'b1;
    end else if (src == A_BRPT1R) begin
      drv_data = pointer_q[15:8];
      drv_oe   = 1'b1;
    end else if (src == A_PC0) begin
      drv_data = pcn[7:0];
      drv_oe   = 1'b1;
    end else if (src == A_PC1) begin
      drv_data = pcn[15:8];
      drv_oe   = 1'b1;
    end
  end

  // Next-state: PC advances past the addressed half-word, pointer bytes load
  // from the resolved bus when they are the move destination.
  always_comb begin
    pcr_d     = pcn;
    pc0_d     = pc[0];
    pointer_d = pointer_q;
    if (dst == A_BRPT0) begin
      pointer_d[7:0] = bus.data_in;
    end
    if (dst == A_BRPT1) begin
      pointer_d[15:8] = bus.data_in;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcr_q     <= 16'h0000;
      pc0_q     <= 1'b0;
      pointer_q <= 16'h0000;
    end else begin
      pcr_q     <= pcr_d;
      pc0_q     <= pc0_d;
      pointer_q <= pointer_d;
    end
  end

  assign bus.rom_addr  = pc[10:1];
  assign bus.data_out  = drv_data;
  assign bus.data_oe   = drv_oe;
  assign bus.imm       = imm;
  assign bus.instr_dst = dst;
  assign bus.instr_src = src;

`ifdef PC_DEBUG_EN
  logic [15:0] dbg_pc_q;

  // Delay the PC by one clock so it lines up with the instruction it fetched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_pc_q <= 16'h0000;
    end else begin
      dbg_pc_q <= pc;
    end
  end

  assign dbg_pc      = dbg_pc_q;
  assign dbg_instr   = instr;
  assign dbg_pointer = pointer_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oisc8_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_oisc8_fetch_unit
// Purpose  : Self-checking bench for oisc8_fetch_unit. A ROM array feeds the
//            DUT through a one-clock registered read; a reference model that
//            tracks the program counter, branch pointer and the instruction
//            at each address predicts every decode / bus / address output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oisc8_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  oisc8_fetch_unit_if #(.SAWIDTH(7), .DAWIDTH(5)) bus ();

`ifdef PC_DEBUG_EN
  logic [15:0] dbg_pc;
  logic [12:0] dbg_instr;
  logic [15:0] dbg_pointer;
`endif

  oisc8_fetch_unit #(.SAWIDTH(7), .DAWIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PC_DEBUG_EN
    ,
    .dbg_pc      (dbg_pc),
    .dbg_instr   (dbg_instr),
    .dbg_pointer (dbg_pointer)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM
  logic [26:0] mem [0:1023];
  logic [26:0] rom_q = '0;
  always @(posedge clk) rom_q <= mem[bus.rom_addr];
  assign bus.rom_data = rom_q;

  // Reference model state
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] m_pcr;      // address that follows sequentially
  logic [15:0] m_ptr;      // branch pointer
  logic [15:0] m_pc;       // address fetched in the current cycle
  logic [12:0] m_instr;    // instruction being decoded this cycle
  bit          m_valid;

  function automatic logic [12:0] mv(input logic [4:0] d, input logic [6:0] s);
    return {1'b0, d, s};
  endfunction

  // Instruction stored at a 16-bit program address (two per ROM word, even
  // address in the low half).
  function automatic logic [12:0] instr_at(input logic [15:0] a);
    logic [26:0] w;
    w = mem[(a / 16'd2) % 16'd1024];
    return (a % 16'd2 == 16'd1) ? w[26:14] : w[13:1];
  endfunction

  task automatic set_instr(input logic [15:0] a, input logic [12:0] ins);
    int idx;
    idx = int'((a / 16'd2) % 16'd1024);
    if (a % 16'd2 == 16'd1) mem[idx][26:14] = ins;
    else                    mem[idx][13:1]  = ins;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Predict this cycle's outputs from the model and compare.
  task automatic check_cycle();
    bit          isimm;
    logic [4:0]  d;
    logic [6:0]  s;
    logic [15:0] nxt;
    logic [7:0]  e_out;
    bit          e_oe;
    isimm = m_instr[12];
    d     = m_instr[11:7];
    s     = isimm ? 7'd0 : m_instr[6:0];
    if (rst === 1'b0)                             m_pc = 16'h0000;
    else if (d == 5'd3 && bus.data_in == 8'h00)   m_pc = m_ptr;
    else                                          m_pc = m_pcr;
    nxt = m_pc + 16'd1;
    chk("rom_addr", 32'(bus.rom_addr), 32'((m_pc / 16'd2) % 16'd1024));
    if (rst === 1'b1 && m_valid) begin
      e_oe  = 1'b1;
      e_out = 8'h00;
      if (isimm) e_out = m_instr[7:0];
      else begin
        case (s)
          7'd0:    e_out = 8'h00;
          7'd1:    e_out = 8'(m_ptr % 16'd256);
          7'd2:    e_out = 8'(m_ptr / 16'd256);
          7'd3:    e_out = 8'(nxt % 16'd256);
          7'd4:    e_out = 8'(nxt / 16'd256);
          default: e_oe  = 1'b0;
        endcase
      end
      chk("imm",       32'(bus.imm),       32'(isimm));
      chk("instr_dst", 32'(bus.instr_dst), 32'(d));
      chk("instr_src", 32'(bus.instr_src), 32'(s));
      chk("data_oe",   32'(bus.data_oe),   32'(e_oe));
      chk("data_out",  32'(bus.data_out),  32'(e_out));
`ifdef PC_DEBUG_EN
      chk("dbg_pointer", 32'(dbg_pointer), 32'(m_ptr));
`endif
    end
  endtask

  // Drive bus data for this cycle and check at the falling edge.
  task automatic at(input logic [7:0] din);
    bus.data_in = din;
    @(negedge clk);
    check_cycle();
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    logic [4:0] d;
    @(posedge clk);
    d = m_instr[11:7];
    if (rst === 1'b1) begin
      if (m_valid && d == 5'd1) m_ptr = (m_ptr & 16'hFF00) | 16'(bus.data_in);
      if (m_valid && d == 5'd2) m_ptr = (m_ptr & 16'h00FF) | (16'(bus.data_in) << 8);
      m_pcr = m_pc + 16'd1;
    end else begin
      m_pcr = 16'h0000;
      m_ptr = 16'h0000;
    end
    m_instr = instr_at(m_pc);
    m_valid = 1'b1;
    #1;
  endtask

  // Main directed-then-random sequence
  initial begin
    logic [7:0] din;
    rst         = 1'b0;
    bus.data_in = 8'h55;
    m_pcr       = 16'h0000;
    m_ptr       = 16'h0000;
    m_pc        = 16'h0000;
    m_instr     = 13'h0000;
    m_valid     = 1'b0;

    for (int i = 0; i < 1024; i++) mem[i] = 27'($urandom);
    mem[0] = {13'h1FFF, 13'h0000, 1'b0};
    set_instr(16'h0002, 13'h10A5);
    set_instr(16'h0003, mv(5'd1,  7'h7F));
    set_instr(16'h0004, mv(5'd2,  7'h7F));
    set_instr(16'h0005, mv(5'h1F, 7'd2));
    set_instr(16'h0006, mv(5'd3,  7'h7F));
    set_instr(16'h0007, mv(5'd3,  7'h7F));
    set_instr(16'h0134, mv(5'd1,  7'd3));
    set_instr(16'h0135, mv(5'd2,  7'h7F));
    set_instr(16'h0136, mv(5'd3,  7'h7F));
    set_instr(16'h00FE, mv(5'h1F, 7'd3));
    set_instr(16'h00FF, mv(5'd3,  7'h7F));
    set_instr(16'h0100, mv(5'd1,  7'h7F));
    set_instr(16'h0101, mv(5'd2,  7'h7F));
    set_instr(16'h0102, mv(5'd3,  7'h7F));
    set_instr(16'hFFFF, mv(5'h1F, 7'd4));

    // Reset held for three cycles
    for (int k = 0; k < 3; k++) begin
      at(8'h55);
      chk("reset_rom_addr", 32'(bus.rom_addr), 32'h0);
      tick();
    end
    rst = 1'b1;

    // Fetch alternation: B half twice (reset latch + pc 0), then A half
    at(8'h55);  chk("fetch0_addr", 32'(bus.rom_addr), 32'h0);
                chk("fetch0_null_oe", 32'(bus.data_oe), 32'h1);
                chk("fetch0_null_out", 32'(bus.data_out), 32'h00);  tick();
    at(8'h55);  chk("fetch1_addr", 32'(bus.rom_addr), 32'h0);
                chk("fetch1_B_imm", 32'(bus.imm), 32'h0);           tick();
    at(8'h55);  chk("fetch2_addr", 32'(bus.rom_addr), 32'h1);
                chk("fetch2_A_imm", 32'(bus.imm), 32'h1);
                chk("fetch2_A_out", 32'(bus.data_out), 32'hFF);     tick();
    // Immediate 13'h10A5
    at(8'hA5);  chk("fetch3_addr", 32'(bus.rom_addr), 32'h1);
                chk("imm_flag", 32'(bus.imm), 32'h1);
                chk("imm_src", 32'(bus.instr_src), 32'h0);
                chk("imm_out", 32'(bus.data_out), 32'hA5);
                chk("imm_oe", 32'(bus.data_oe), 32'h1);             tick();
    // Pointer writes 0x34 / 0x01, unknown source leaves bus undriven
    at(8'h34);  chk("fetch4_addr", 32'(bus.rom_addr), 32'h2);
                chk("unknown_src_oe", 32'(bus.data_oe), 32'h0);     tick();
    at(8'h01);  tick();
    at(8'h55);  chk("brpt1r_out", 32'(bus.data_out), 32'h01);
                chk("brpt1r_oe", 32'(bus.data_oe), 32'h1);          tick();
    // BRZ with 0x01 falls through, then BRZ with 0x00 branches to 0x0134
    at(8'h01);  chk("brz_nt_addr", 32'(bus.rom_addr), 32'h3);       tick();
    at(8'h00);  chk("brz_taken_addr", 32'(bus.rom_addr), 32'h09A);  tick();
    at(8'hFE);  chk("after_branch_addr", 32'(bus.rom_addr), 32'h09A);
                chk("after_branch_pcn_lo", 32'(bus.data_out), 32'h36); tick();
    at(8'h00);  tick();
    at(8'h00);  chk("jump_00fe_addr", 32'(bus.rom_addr), 32'h07F);  tick();
    // Readback at pc 0x00FF: PC0 then (second pass) PC1
    at(8'h55);  chk("pc0_at_00ff", 32'(bus.data_out), 32'h00);
                chk("pc0_at_00ff_oe", 32'(bus.data_oe), 32'h1);     tick();
    at(8'h00);  set_instr(16'h00FE, mv(5'h1F, 7'd4));               tick();
    at(8'h55);  chk("pc1_at_00ff", 32'(bus.data_out), 32'h01);      tick();
    at(8'h01);  chk("fallthrough_0100", 32'(bus.rom_addr), 32'h080); tick();
    // Branch to 0xFFFF and wrap to 0x0000
    at(8'hFF);  tick();
    at(8'hFF);  tick();
    at(8'h00);  chk("jump_ffff_addr", 32'(bus.rom_addr), 32'h3FF);  tick();
    at(8'h55);  chk("wrap_addr", 32'(bus.rom_addr), 32'h000);
                chk("wrap_pcn_hi", 32'(bus.data_out), 32'h00);      tick();

    // Random program with an asynchronous reset pulse in the middle
    for (int n = 0; n < 400; n++) begin
      din = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      at(din);
      tick();
      if (n == 200) begin
        rst     = 1'b0;
        m_pcr   = 16'h0000;
        m_ptr   = 16'h0000;
        m_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
          at(8'($urandom));
          chk("midrun_reset_addr", 32'(bus.rom_addr), 32'h0);
          tick();
        end
        rst = 1'b1;
        at(8'h55);  chk("restart_addr0", 32'(bus.rom_addr), 32'h0); tick();
        at(8'h55);  chk("restart_addr1", 32'(bus.rom_addr), 32'h0); tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
